// File: rtl/mem_arbiter_if.sv
// One requestor port of the data-RAM arbiter: request/address/data in, grant and
// read return out. The requestor uses the master modport, the arbiter the slave.
interface mem_arbiter_if #(
   parameter int unsigned WORD_SIZE  = 20,
   parameter int unsigned ADDR_WIDTH = 16
) ();
   logic                  req;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WORD_SIZE-1:0]  wdata;
   logic                  we;
   logic                  lock;
   logic                  gnt;
   logic                  rvalid;
   logic [WORD_SIZE-1:0]  rdata;

   modport master (
      output req, addr, wdata, we, lock,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, wdata, we, lock,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with optional bus lock in front of the single-port data RAM.
// Tracks the RAM's one-cycle read latency and steers rvalid to the issuing master.
module mem_arbiter #(
   parameter int unsigned WORD_SIZE  = 20,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   mem_arbiter_if.slave         m0,
   mem_arbiter_if.slave         m1,
   output logic [WORD_SIZE-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0] mem_value_o,
   output logic                 mem_write_o,
   input  logic [WORD_SIZE-1:0] mem_value_i
);

   logic                  last_gnt_q;
   logic                  locked_q;
   logic                  lock_owner_q;
   logic                  rd_pending_q;
   logic                  rd_owner_q;
   logic [WORD_SIZE-1:0]  addr_q;
   logic [WORD_SIZE-1:0]  value_q;

   logic                  gnt_valid;
   logic                  gnt_sel;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [WORD_SIZE-1:0]  sel_addr_ext;
   logic [WORD_SIZE-1:0]  sel_wdata;
   logic                  sel_we;
   logic                  sel_lock;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_sel   = 1'b0;
      if (locked_q && (lock_owner_q ? m1.req : m0.req)) begin
         gnt_valid = 1'b1;
         gnt_sel   = lock_owner_q;
      end else if (m0.req && m1.req) begin
         gnt_valid = 1'b1;
         gnt_sel   = ~last_gnt_q;
      end else if (m0.req) begin
         gnt_valid = 1'b1;
         gnt_sel   = 1'b0;
      end else if (m1.req) begin
         gnt_valid = 1'b1;
         gnt_sel   = 1'b1;
      end
      // Grants are combinational, so suppress them while reset is held.
      if (!reset_n) begin
         gnt_valid = 1'b0;
      end
   end

   always_comb begin
      sel_addr  = gnt_sel ? m1.addr  : m0.addr;
      sel_wdata = gnt_sel ? m1.wdata : m0.wdata;
      sel_we    = gnt_sel ? m1.we    : m0.we;
      sel_lock  = gnt_sel ? m1.lock  : m0.lock;
   end

   assign sel_addr_ext = {{(WORD_SIZE - ADDR_WIDTH){1'b0}}, sel_addr};

   assign m0.gnt = gnt_valid & ~gnt_sel;
   assign m1.gnt = gnt_valid & gnt_sel;

   // With no grant the RAM keeps seeing the last address; the resulting read is unused.
   assign mem_addr_o  = gnt_valid ? sel_addr_ext : addr_q;
   assign mem_value_o = gnt_valid ? sel_wdata    : value_q;
   assign mem_write_o = gnt_valid & sel_we;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt_q   <= 1'b1;
         locked_q     <= 1'b0;
         lock_owner_q <= 1'b0;
         rd_pending_q <= 1'b0;
         rd_owner_q   <= 1'b0;
         addr_q       <= '0;
         value_q      <= '0;
      end else if (gnt_valid) begin
         last_gnt_q   <= gnt_sel;
         locked_q     <= sel_lock;
         lock_owner_q <= gnt_sel;
         rd_pending_q <= ~sel_we;
         rd_owner_q   <= gnt_sel;
         addr_q       <= sel_addr_ext;
         value_q      <= sel_wdata;
      end else begin
         rd_pending_q <= 1'b0;
         locked_q     <= 1'b0;
      end
   end

   assign m0.rvalid = rd_pending_q & ~rd_owner_q;
   assign m1.rvalid = rd_pending_q & rd_owner_q;
   assign m0.rdata  = mem_value_i;
   assign m1.rdata  = mem_value_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural registered-read RAM.
// Each row drives both masters for one cycle and checks grant, RAM strobe and read return.
module tb_mem_arbiter;

   localparam logic [2:0] NO = 3'b000;  // {req, we, lock}
   localparam logic [2:0] RD = 3'b100;
   localparam logic [2:0] WR = 3'b110;
   localparam logic [2:0] RL = 3'b101;
   localparam logic [2:0] GN  = 3'b000; // {gnt0, gnt1, mem_write}
   localparam logic [2:0] G0  = 3'b100;
   localparam logic [2:0] G0W = 3'b101;
   localparam logic [2:0] G1  = 3'b010;
   localparam logic [2:0] G1W = 3'b011;
   localparam logic [1:0] VN = 2'b00;   // {rvalid0, rvalid1}
   localparam logic [1:0] V0 = 2'b10;
   localparam logic [1:0] V1 = 2'b01;

   typedef struct {
      logic [2:0]  c0;
      logic [15:0] a0;
      logic [19:0] d0;
      logic [2:0]  c1;
      logic [15:0] a1;
      logic [19:0] d1;
      logic [2:0]  eg;
      logic [19:0] eaddr;
      logic [1:0]  ev;
      logic [19:0] erd;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic [19:0] mem_addr;
   logic [19:0] mem_value;
   logic        mem_write;
   logic [19:0] ram_q;
   logic [19:0] ram [0:511];

   int n_checks;
   int n_fail;

   mem_arbiter_if #(.WORD_SIZE(20), .ADDR_WIDTH(16)) m0_if ();
   mem_arbiter_if #(.WORD_SIZE(20), .ADDR_WIDTH(16)) m1_if ();

   mem_arbiter #(
      .WORD_SIZE  (20),
      .ADDR_WIDTH (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m0          (m0_if),
      .m1          (m1_if),
      .mem_addr_o  (mem_addr),
      .mem_value_o (mem_value),
      .mem_write_o (mem_write),
      .mem_value_i (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: write on the strobe, registered read one cycle later.
   always @(posedge clk) begin
      if (mem_write) ram[mem_addr[8:0]] <= mem_value;
      ram_q <= ram[mem_addr[8:0]];
   end

   function automatic vec_t mk(input logic [2:0] c0, input logic [15:0] a0,
                               input logic [19:0] d0, input logic [2:0] c1,
                               input logic [15:0] a1, input logic [19:0] d1,
                               input logic [2:0] eg, input logic [19:0] eaddr,
                               input logic [1:0] ev, input logic [19:0] erd);
      vec_t v;
      v.c0 = c0; v.a0 = a0; v.d0 = d0;
      v.c1 = c1; v.a1 = a1; v.d1 = d1;
      v.eg = eg; v.eaddr = eaddr; v.ev = ev; v.erd = erd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      m0_if.req = v.c0[2]; m0_if.we = v.c0[1]; m0_if.lock = v.c0[0];
      m0_if.addr = v.a0;   m0_if.wdata = v.d0;
      m1_if.req = v.c1[2]; m1_if.we = v.c1[1]; m1_if.lock = v.c1[0];
      m1_if.addr = v.a1;   m1_if.wdata = v.d1;
   endtask

   task automatic run_row(input string tag, input vec_t v);
      drive(v);
      @(negedge clk);
      chk({tag, " gnt0"}, 32'(m0_if.gnt), 32'(v.eg[2]));
      chk({tag, " gnt1"}, 32'(m1_if.gnt), 32'(v.eg[1]));
      chk({tag, " mem_write"}, 32'(mem_write), 32'(v.eg[0]));
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.eaddr));
      chk({tag, " rvalid0"}, 32'(m0_if.rvalid), 32'(v.ev[1]));
      chk({tag, " rvalid1"}, 32'(m1_if.rvalid), 32'(v.ev[0]));
      if (v.ev[1]) chk({tag, " rdata0"}, 32'(m0_if.rdata), 32'(v.erd));
      if (v.ev[0]) chk({tag, " rdata1"}, 32'(m1_if.rdata), 32'(v.erd));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " gnt0"}, 32'(m0_if.gnt), 32'd0);
      chk({tag, " gnt1"}, 32'(m1_if.gnt), 32'd0);
      chk({tag, " rvalid0"}, 32'(m0_if.rvalid), 32'd0);
      chk({tag, " rvalid1"}, 32'(m1_if.rvalid), 32'd0);
      chk({tag, " mem_write"}, 32'(mem_write), 32'd0);
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, " mem_value"}, 32'(mem_value), 32'd0);
   endtask

   vec_t preload[$];
   vec_t main_tbl[$];
   vec_t both_rd;

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Writes through m1 to load the RAM; writes must never raise rvalid.
      preload.push_back(mk(NO, 0, 0, WR, 16'h0001, 20'hAAAAA, G1W, 20'h00001, VN, 0));
      preload.push_back(mk(NO, 0, 0, WR, 16'h0002, 20'h55555, G1W, 20'h00002, VN, 0));
      preload.push_back(mk(NO, 0, 0, WR, 16'h0003, 20'hCAFE3, G1W, 20'h00003, VN, 0));
      preload.push_back(mk(NO, 0, 0, WR, 16'h0100, 20'h11111, G1W, 20'h00100, VN, 0));
      preload.push_back(mk(NO, 0, 0, WR, 16'h0101, 20'h22222, G1W, 20'h00101, VN, 0));
      preload.push_back(mk(NO, 0, 0, WR, 16'h0102, 20'h33333, G1W, 20'h00102, VN, 0));
      preload.push_back(mk(NO, 0, 0, WR, 16'h0103, 20'h44444, G1W, 20'h00103, VN, 0));

      // Round-robin reads after reset, then idle, pipeline, and lock burst.
      both_rd = mk(RD, 16'h0001, 0, RD, 16'h0002, 0, G0, 20'h00001, VN, 0);
      main_tbl.push_back(both_rd);
      main_tbl.push_back(mk(RD, 16'h0001, 0, RD, 16'h0002, 0, G1, 20'h00002, V0, 20'hAAAAA));
      main_tbl.push_back(mk(RD, 16'h0001, 0, RD, 16'h0002, 0, G0, 20'h00001, V1, 20'h55555));
      main_tbl.push_back(mk(NO, 0, 0, NO, 0, 0, GN, 20'h00001, V0, 20'hAAAAA));
      for (int i = 0; i < 4; i++) main_tbl.push_back(mk(NO, 0, 0, NO, 0, 0, GN, 20'h1, VN, 0));
      main_tbl.push_back(mk(WR, 16'h0010, 20'h12345, NO, 0, 0, G0W, 20'h00010, VN, 0));
      main_tbl.push_back(mk(RD, 16'h0010, 0, NO, 0, 0, G0, 20'h00010, VN, 0));
      main_tbl.push_back(mk(RD, 16'h0003, 0, RL, 16'h0100, 0, G1, 20'h00100, V0, 20'h12345));
      main_tbl.push_back(mk(RD, 16'h0003, 0, RL, 16'h0101, 0, G1, 20'h00101, V1, 20'h11111));
      main_tbl.push_back(mk(RD, 16'h0003, 0, RL, 16'h0102, 0, G1, 20'h00102, V1, 20'h22222));
      main_tbl.push_back(mk(RD, 16'h0003, 0, RL, 16'h0103, 0, G1, 20'h00103, V1, 20'h33333));
      main_tbl.push_back(mk(RD, 16'h0003, 0, NO, 0, 0, G0, 20'h00003, V1, 20'h44444));
      main_tbl.push_back(mk(NO, 0, 0, NO, 0, 0, GN, 20'h00003, V0, 20'hCAFE3));
      main_tbl.push_back(mk(NO, 0, 0, NO, 0, 0, GN, 20'h00003, VN, 0));

      // Reset held with both masters requesting.
      reset_n = 1'b0;
      drive(both_rd);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset("reset_hold");
      @(posedge clk);
      #1;
      drive(mk(NO, 0, 0, NO, 0, 0, GN, 0, VN, 0));
      reset_n = 1'b1;

      foreach (preload[i]) run_row($sformatf("preload[%0d]", i), preload[i]);

      // Reset asserted the cycle after an m0 read grant: the read must be dropped.
      run_row("rd_before_reset", mk(RD, 16'h0001, 0, NO, 0, 0, G0, 20'h00001, VN, 0));
      reset_n = 1'b0;
      drive(both_rd);
      @(negedge clk);
      chk_reset("reset_mid_read");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      foreach (main_tbl[i]) run_row($sformatf("main[%0d]", i), main_tbl[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
